// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, then a sign-fix cycle.
module mdu_hilo #(
    parameter int unsigned data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            md_op,
    input  logic [data_width-1:0] in_s1,
    input  logic [data_width-1:0] in_s2,
    input  logic                  mthi,
    input  logic                  mtlo,
    input  logic [data_width-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [data_width-1:0] hi,
    output logic [data_width-1:0] lo
);

    localparam int unsigned W    = data_width;
    localparam int unsigned CntW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            div_q;
    logic            neg_res_q;
    logic            neg_rem_q;
    logic            dz_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    s1_q;
    logic [2*W-1:0]  acc_q;
    logic [W-1:0]    hi_q;
    logic [W-1:0]    lo_q;
    logic            done_q;
    logic            dbz_q;

    logic            op_div;
    logic            op_signed;
    logic [W-1:0]    s1_abs;
    logic [W-1:0]    s2_abs;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_acc_d;
    logic [W:0]      rem_sh;
    logic [W:0]      rem_diff;
    logic [2*W-1:0]  div_acc_d;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quo_fix;
    logic [W-1:0]    rem_fix;

    assign op_div    = md_op[1];
    assign op_signed = ~md_op[0];

    always_comb begin
        s1_abs = (op_signed && in_s1[W-1]) ? (~in_s1 + 1'b1) : in_s1;
        s2_abs = (op_signed && in_s2[W-1]) ? (~in_s2 + 1'b1) : in_s2;
    end

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : {(W + 1){1'b0}});
        mul_acc_d = {mul_sum, acc_q[W-1:1]};
    end

    // Divide: acc = {partial remainder, dividend/quotient}, shifted left each step.
    // Bit W of the difference is the borrow: set when the shifted remainder is below the divisor.
    always_comb begin
        rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
        rem_diff = rem_sh - {1'b0, a_q};
        if (!rem_diff[W]) begin
            div_acc_d = {rem_diff[W-1:0], acc_q[W-2:0], 1'b1};
        end else begin
            div_acc_d = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix  = neg_res_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
        rem_fix  = neg_rem_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            a_q       <= '0;
            s1_q      <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        div_q     <= op_div;
                        neg_res_q <= op_signed & (in_s1[W-1] ^ in_s2[W-1]);
                        neg_rem_q <= op_signed & in_s1[W-1];
                        dz_q      <= op_div & (in_s2 == '0);
                        s1_q      <= in_s1;
                        a_q       <= op_div ? s2_abs : s1_abs;
                        acc_q     <= {{W{1'b0}}, (op_div ? s1_abs : s2_abs)};
                        cnt_q     <= '0;
                        dbz_q     <= 1'b0;
                        state_q   <= StCalc;
                    end else begin
                        if (mthi) hi_q <= wr_data;
                        if (mtlo) lo_q <= wr_data;
                    end
                end
                StCalc: begin
                    acc_q <= div_q ? div_acc_d : mul_acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_q <= StFin;
                    end
                end
                StFin: begin
                    if (!div_q) begin
                        hi_q <= prod_fix[2*W-1:W];
                        lo_q <= prod_fix[W-1:0];
                    end else if (dz_q) begin
                        hi_q <= s1_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                    dbz_q   <= div_q & dz_q;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed self-checking bench for mdu_hilo: multiply, divide, MTHI/MTLO, abort and back-to-back.
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] in_s1;
    logic [31:0] in_s2;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mdu_hilo #(.data_width(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .md_op       (md_op),
        .in_s1       (in_s1),
        .in_s2       (in_s2),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    // Caller is at a negedge; start is seen by the next rising edge.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        md_op = op;
        in_s1 = a;
        in_s2 = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit to);
        cyc = 0;
        to  = 1'b0;
        while (done !== 1'b1) begin
            if (cyc >= 100) begin
                to = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; md_op = 2'b00; in_s1 = '0; in_s2 = '0;
        mthi = 1'b0; mtlo = 1'b0; wr_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset dbz: got %b want 0", div_by_zero); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset hi: got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset lo: got %h want 0", lo); end
    endtask

    task automatic test_mult;
        int cyc; bit to;
        launch(2'b00, 32'hFFFFFFFD, 32'h00000005);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult busy: got %b want 1", busy); end
        wait_done(cyc, to);
        checks++; if (to) begin errors++; $display("FAIL mult timeout: got no done want done"); end
        checks++; if (cyc != 33) begin errors++; $display("FAIL mult latency: got %0d want 33", cyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult busy_end: got %b want 0", busy); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult hi: got %h want FFFFFFFF", hi); end
        checks++; if (lo !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult lo: got %h want FFFFFFF1", lo); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL mult dbz: got %b want 0", div_by_zero); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult done_pulse: got %b want 0", done); end

        launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(cyc, to);
        checks++; if (to) begin errors++; $display("FAIL multu timeout: got no done want done"); end
        checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu hi: got %h want FFFFFFFE", hi); end
        checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu lo: got %h want 00000001", lo); end
        @(negedge clk);

        launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(cyc, to);
        checks++; if (to) begin errors++; $display("FAIL mult_m1 timeout: got no done want done"); end
        checks++; if (hi !== 32'h00000000) begin errors++; $display("FAIL mult_m1 hi: got %h want 00000000", hi); end
        checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL mult_m1 lo: got %h want 00000001", lo); end
        @(negedge clk);
    endtask

    task automatic test_div;
        int cyc; bit to;
        launch(2'b10, 32'hFFFFFFF9, 32'h00000002);
        wait_done(cyc, to);
        checks++; if (to) begin errors++; $display("FAIL div timeout: got no done want done"); end
        checks++; if (cyc != 33) begin errors++; $display("FAIL div latency: got %0d want 33", cyc); end
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div lo: got %h want FFFFFFFD", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div hi: got %h want FFFFFFFF", hi); end
        @(negedge clk);

        launch(2'b11, 32'h00000007, 32'h00000002);
        wait_done(cyc, to);
        checks++; if (to) begin errors++; $display("FAIL divu timeout: got no done want done"); end
        checks++; if (lo !== 32'h00000003) begin errors++; $display("FAIL divu lo: got %h want 00000003", lo); end
        checks++; if (hi !== 32'h00000001) begin errors++; $display("FAIL divu hi: got %h want 00000001", hi); end
        @(negedge clk);
    endtask

    task automatic test_div_edge;
        int cyc; bit to;
        launch(2'b10, 32'h80000000, 32'hFFFFFFFF);
        wait_done(cyc, to);
        checks++; if (to) begin errors++; $display("FAIL divmin timeout: got no done want done"); end
        checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL divmin lo: got %h want 80000000", lo); end
        checks++; if (hi !== 32'h00000000) begin errors++; $display("FAIL divmin hi: got %h want 00000000", hi); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL divmin dbz: got %b want 0", div_by_zero); end
        @(negedge clk);

        launch(2'b11, 32'h00000005, 32'h00000000);
        wait_done(cyc, to);
        checks++; if (to) begin errors++; $display("FAIL divz timeout: got no done want done"); end
        checks++; if (cyc != 33) begin errors++; $display("FAIL divz latency: got %0d want 33", cyc); end
        checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz lo: got %h want FFFFFFFF", lo); end
        checks++; if (hi !== 32'h00000005) begin errors++; $display("FAIL divz hi: got %h want 00000005", hi); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL divz dbz: got %b want 1", div_by_zero); end
        @(negedge clk);

        launch(2'b10, 32'hFFFFFF9C, 32'h00000000);
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_clear: got %b want 0", div_by_zero); end
        wait_done(cyc, to);
        checks++; if (hi !== 32'hFFFFFF9C) begin errors++; $display("FAIL divz_s hi: got %h want FFFFFF9C", hi); end
        checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divz_s lo: got %h want FFFFFFFF", lo); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL divz_s dbz: got %b want 1", div_by_zero); end
        @(negedge clk);
    endtask

    task automatic test_mthi_mtlo;
        int cyc; bit to;
        logic [31:0] lo_before;
        lo_before = lo;
        mthi = 1'b1; wr_data = 32'h00001234;
        @(negedge clk);
        mthi = 1'b0;
        checks++; if (hi !== 32'h00001234) begin errors++; $display("FAIL mthi hi: got %h want 00001234", hi); end
        checks++; if (lo !== lo_before) begin errors++; $display("FAIL mthi lo: got %h want %h", lo, lo_before); end

        mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h0000ABCD;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        checks++; if (hi !== 32'h0000ABCD) begin errors++; $display("FAIL mtboth hi: got %h want 0000ABCD", hi); end
        checks++; if (lo !== 32'h0000ABCD) begin errors++; $display("FAIL mtboth lo: got %h want 0000ABCD", lo); end

        // mtlo together with an accepted start must be dropped.
        mtlo = 1'b1; wr_data = 32'h11111111;
        launch(2'b00, 32'h00000003, 32'h00000005);
        mtlo = 1'b0;
        checks++; if (lo !== 32'h0000ABCD) begin errors++; $display("FAIL mt_start lo: got %h want 0000ABCD", lo); end
        repeat (4) @(negedge clk);
        start = 1'b1; md_op = 2'b01; in_s1 = 32'h00000100; in_s2 = 32'h00000100;
        mtlo = 1'b1; wr_data = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0;
        checks++; if (lo !== 32'h0000ABCD) begin errors++; $display("FAIL busy_mtlo lo: got %h want 0000ABCD", lo); end
        checks++; if (hi !== 32'h0000ABCD) begin errors++; $display("FAIL calc_hold hi: got %h want 0000ABCD", hi); end
        wait_done(cyc, to);
        checks++; if (to) begin errors++; $display("FAIL busy_ign timeout: got no done want done"); end
        checks++; if (cyc != 28) begin errors++; $display("FAIL busy_ign latency: got %0d want 28", cyc); end
        checks++; if (hi !== 32'h00000000) begin errors++; $display("FAIL busy_ign hi: got %h want 00000000", hi); end
        checks++; if (lo !== 32'h0000000F) begin errors++; $display("FAIL busy_ign lo: got %h want 0000000F", lo); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_ign idle: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int cyc; bit to;
        launch(2'b11, 32'h00000007, 32'h00000002);
        wait_done(cyc, to);
        checks++; if (to) begin errors++; $display("FAIL b2b_first timeout: got no done want done"); end
        launch(2'b01, 32'h00000006, 32'h00000007);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b busy: got %b want 1", busy); end
        checks++; if (lo !== 32'h00000003) begin errors++; $display("FAIL b2b first lo: got %h want 00000003", lo); end
        wait_done(cyc, to);
        checks++; if (cyc != 33) begin errors++; $display("FAIL b2b latency: got %0d want 33", cyc); end
        checks++; if (hi !== 32'h00000000) begin errors++; $display("FAIL b2b hi: got %h want 00000000", hi); end
        checks++; if (lo !== 32'h0000002A) begin errors++; $display("FAIL b2b lo: got %h want 0000002A", lo); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int cyc; bit to;
        bit seen_done;
        launch(2'b10, 32'h00000064, 32'h00000007);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort busy: got %b want 0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL abort hi: got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL abort lo: got %h want 0", lo); end
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        checks++; if (seen_done) begin errors++; $display("FAIL abort done: got 1 want 0"); end
        launch(2'b11, 32'h00000064, 32'h00000007);
        wait_done(cyc, to);
        checks++; if (to) begin errors++; $display("FAIL post_abort timeout: got no done want done"); end
        checks++; if (lo !== 32'h0000000E) begin errors++; $display("FAIL post_abort lo: got %h want 0000000E", lo); end
        checks++; if (hi !== 32'h00000002) begin errors++; $display("FAIL post_abort hi: got %h want 00000002", hi); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_edge();
        test_mthi_mtlo();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
